// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated
// rep_cnt times with optional idle gaps, ending with a one-cycle done pulse.
module seq_pattern_gen #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             idle_val,
    input  logic             abort,
    output logic             out_seq,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             idle_val_q, idle_val_d;
    logic             done_pend_q, done_pend_d;
    logic             out_seq_q, out_seq_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The state register selects the bit to present next; the output flops then
    // show it one edge later, which gives the single cycle of start latency.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        idx_d         = idx_q;
        rem_d         = rem_q;
        gap_cnt_d     = gap_cnt_q;
        pat_d         = pat_q;
        gap_len_d     = gap_len_q;
        idle_val_d    = idle_val_q;
        done_pend_d   = 1'b0;
        out_seq_d     = idle_val_q;
        out_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = done_pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    if (rep_cnt != '0) begin
                        pat_d      = pattern;
                        gap_len_d  = gap_len;
                        idle_val_d = idle_val;
                        rem_d      = rep_cnt;
                        idx_d      = IDX_MSB;
                        state_d    = S_SEND;
                    end else begin
                        done_pend_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                busy_d        = 1'b1;
                out_valid_d   = 1'b1;
                out_seq_d     = pat_q[idx_q];
                frame_start_d = (idx_q == IDX_MSB);
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else if (rem_q == CNT_W'(1)) begin
                    rem_d       = '0;
                    done_pend_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                    if (gap_len_q != '0) begin
                        gap_cnt_d = gap_len_q - GAP_W'(1);
                        state_d   = S_GAP;
                    end else begin
                        idx_d = IDX_MSB;
                    end
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == '0) begin
                    idx_d   = IDX_MSB;
                    state_d = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            done_pend_d   = 1'b0;
            out_seq_d     = idle_val_q;
            out_valid_d   = 1'b0;
            frame_start_d = 1'b0;
            busy_d        = 1'b0;
        end
    end

    // NOTE: all state, including the captured operands, is cleared by reset so a
    // mid-transfer reset can never leak a stale pattern or idle level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            rem_q         <= '0;
            gap_cnt_q     <= '0;
            pat_q         <= '0;
            gap_len_q     <= '0;
            idle_val_q    <= 1'b0;
            done_pend_q   <= 1'b0;
            out_seq_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q       <= state_d;
            idx_q         <= idx_d;
            rem_q         <= rem_d;
            gap_cnt_q     <= gap_cnt_d;
            pat_q         <= pat_d;
            gap_len_q     <= gap_len_d;
            idle_val_q    <= idle_val_d;
            done_pend_q   <= done_pend_d;
            out_seq_q     <= out_seq_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign out_seq     = out_seq_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule
